// File: rtl/time_keeper.sv
// Purpose : real-time BCD clock (HH:MM:SS) with set mode and a once-per-minute strobe.
// Latency : digits and minTick are registered; they update on the clk edge that ends a second or sees a button edge.
// Backpressure: none; the counter free-runs and consumers sample the outputs whenever they like.
//
// Ports:
//   clk, resetN          - clock (rising edge) and asynchronous active-low reset
//   setMode              - 1 holds time (seconds cleared, prescaler frozen) and enables the buttons
//   incMin, incHour      - level buttons; each rising edge bumps minutes/hours while setMode=1
//   curSec0..curHour1    - BCD digits of the current time
//   minTick              - one-cycle pulse in the first cycle a new minute value is visible
//   pm                   - afternoon flag, only with TIME12H_EN defined
// Build option: define TIME12H_EN for 12-hour hour digits plus the pm port; default is 24-hour.
module time_keeper #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       setMode,
    input  logic       incMin,
    input  logic       incHour,
    output logic [3:0] curSec0,
    output logic [3:0] curSec1,
    output logic [3:0] curMin0,
    output logic [3:0] curMin1,
    output logic [3:0] curHour0,
    output logic [3:0] curHour1,
    output logic       minTick
`ifdef TIME12H_EN
    ,
    output logic       pm
`endif
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

    // Time held as packed BCD pairs: [7:4] tens, [3:0] units. Hours count 00-23.
    logic [7:0]    sec, secNext;
    logic [7:0]    min, minNext;
    logic [7:0]    hour, hourNext;
    logic [PW-1:0] presc;
    logic          incMinPrev, incHourPrev;
    logic          minChange;
    logic          secTick;
    logic          minEdge, hourEdge;

    // BCD increment of a 00-59 pair, wrapping 59 -> 00.
    function automatic logic [7:0] incMod60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD increment of a 00-23 pair, wrapping 23 -> 00.
    function automatic logic [7:0] incMod24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign secTick  = !setMode && (presc == LAST_TICK);
    assign minEdge  = incMin & ~incMinPrev;
    assign hourEdge = incHour & ~incHourPrev;

    // All carries are resolved here so every digit moves on the same edge;
    // a value like 23:60 never reaches the registers.
    always_comb begin
        secNext   = sec;
        minNext   = min;
        hourNext  = hour;
        minChange = 1'b0;
        if (setMode) begin
            secNext = 8'h00;
            // Set-mode minute wrap deliberately does not carry into hours.
            if (minEdge) begin
                minNext   = incMod60(min);
                minChange = 1'b1;
            end
            if (hourEdge)
                hourNext = incMod24(hour);
        end else if (secTick) begin
            secNext = incMod60(sec);
            if (sec == 8'h59) begin
                minNext   = incMod60(min);
                minChange = 1'b1;
                if (min == 8'h59)
                    hourNext = incMod24(hour);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            presc       <= '0;
            sec         <= 8'h00;
            min         <= 8'h00;
            hour        <= 8'h00;
            minTick     <= 1'b0;
            incMinPrev  <= 1'b0;
            incHourPrev <= 1'b0;
        end else begin
            // Held at 0 in set mode so the first second after leaving it is a full one.
            if (setMode || presc == LAST_TICK)
                presc <= '0;
            else
                presc <= presc + 1'b1;
            sec         <= secNext;
            min         <= minNext;
            hour        <= hourNext;
            minTick     <= minChange;
            // Tracked in every mode so a button already held when set mode starts is not an edge.
            incMinPrev  <= incMin;
            incHourPrev <= incHour;
        end
    end

    assign curSec0 = sec[3:0];
    assign curSec1 = sec[7:4];
    assign curMin0 = min[3:0];
    assign curMin1 = min[7:4];

`ifdef TIME12H_EN
    logic [7:0] hourDisp;
    logic       pmFlag;

    // 00 shows as 12 AM, 12 as 12 PM, 13-23 as 01-11 PM; counting itself stays 24-hour.
    always_comb begin
        hourDisp = hour;
        pmFlag   = 1'b0;
        case (hour)
            8'h00: hourDisp = 8'h12;
            8'h12: pmFlag = 1'b1;
            8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19: begin
                hourDisp = {4'h0, hour[3:0] - 4'd2};
                pmFlag   = 1'b1;
            end
            8'h20, 8'h21: begin
                hourDisp = {4'h0, hour[3:0] + 4'd8};
                pmFlag   = 1'b1;
            end
            8'h22, 8'h23: begin
                hourDisp = {4'h1, hour[3:0] - 4'd2};
                pmFlag   = 1'b1;
            end
            default: ;
        endcase
    end

    assign curHour0 = hourDisp[3:0];
    assign curHour1 = hourDisp[7:4];
    assign pm       = pmFlag;
`else
    assign curHour0 = hour[3:0];
    assign curHour1 = hour[7:4];
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper with TICKS_PER_SEC=4: expected snapshots {minTick, pm, HHMMSS}
// are queued as stimulus is driven and compared when the DUT output is sampled.
// Works for both the 24-hour build and the TIME12H_EN build.
module tb_time_keeper;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       setMode;
    logic       incMin;
    logic       incHour;
    logic [3:0] curSec0, curSec1, curMin0, curMin1, curHour0, curHour1;
    logic       minTick;
    logic       pmVal;

`ifdef TIME12H_EN
    logic pm;
    assign pmVal = pm;
`else
    assign pmVal = 1'b0;
`endif

    time_keeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .setMode  (setMode),
        .incMin   (incMin),
        .incHour  (incHour),
        .curSec0  (curSec0),
        .curSec1  (curSec1),
        .curMin0  (curMin0),
        .curMin1  (curMin1),
        .curHour0 (curHour0),
        .curHour1 (curHour1),
        .minTick  (minTick)
`ifdef TIME12H_EN
        ,
        .pm       (pm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [25:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   tickCnt = 0;
    int   tickEdge = 0;
    int   edges;
    int   t0;

    // Edge count since reset release, used to time-stamp minTick.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) edges <= 0;
        else         edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (resetN && minTick) begin
            tickCnt  = tickCnt + 1;
            tickEdge = edges;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected output for a 24-hour BCD time; the hour is converted for the 12-hour build.
    function automatic logic [25:0] mk(input logic [23:0] t, input logic tick);
        int   h;
        logic p;
        h = int'(t[23:20]) * 10 + int'(t[19:16]);
`ifdef TIME12H_EN
        p = (h >= 12);
        h = h % 12;
        if (h == 0) h = 12;
`else
        p = 1'b0;
`endif
        return {tick, p, 4'(h / 10), 4'(h % 10), t[15:0]};
    endfunction

    function automatic logic [25:0] observed();
        return {minTick, pmVal, curHour1, curHour0, curMin1, curMin0, curSec1, curSec0};
    endfunction

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [23:0] t, input logic tick);
        exp_t e;
        e.tag = tag;
        e.v   = mk(t, tick);
        sb.push_back(e);
    endtask

    task automatic popCheck();
        exp_t e;
        e = sb.pop_front();
        checkVal(e.tag, {6'd0, observed()}, {6'd0, e.v});
    endtask

    task automatic expectNow(input string tag, input logic [23:0] t, input logic tick);
        push(tag, t, tick);
        popCheck();
    endtask

    task automatic run(input int n, input string tag, input logic [23:0] t, input logic tick);
        push(tag, t, tick);
        cycle(n);
        popCheck();
    endtask

    task automatic pulse(input logic m, input logic h);
        incMin  = m;
        incHour = h;
        cycle(1);
        incMin  = 1'b0;
        incHour = 1'b0;
        cycle(1);
    endtask

    task automatic doReset();
        #2 resetN = 1'b0;
        cycle(2);
        resetN = 1'b1;
    endtask

    initial begin
        resetN  = 1'b0;
        setMode = 1'b0;
        incMin  = 1'b0;
        incHour = 1'b0;
        #2 expectNow("resetState", 24'h000000, 1'b0);
        cycle(2);
        expectNow("resetHeld", 24'h000000, 1'b0);
        resetN = 1'b1;

        // One minute of free running from reset.
        run(3,   "presc3",   24'h000000, 1'b0);
        run(1,   "firstSec", 24'h000001, 1'b0);
        run(235, "sec59",    24'h000059, 1'b0);
        run(1,   "min1",     24'h000100, 1'b1);
        run(1,   "tickOff",  24'h000100, 1'b0);
        checkVal("tickCount", tickCnt, 1);
        checkVal("tickEdge", tickEdge, 240);

        // Set 23:59 then roll over to midnight.
        doReset();
        setMode = 1'b1;
        cycle(1);
        t0 = tickCnt;
        repeat (13) pulse(1'b0, 1'b1);
        expectNow("hour13", 24'h130000, 1'b0);
        repeat (10) pulse(1'b0, 1'b1);
        expectNow("hour23", 24'h230000, 1'b0);
        checkVal("hourNoTick", tickCnt - t0, 0);
        incMin = 1'b1;
        run(1, "setMinTick", 24'h230100, 1'b1);
        incMin = 1'b0;
        run(1, "setTickOff", 24'h230100, 1'b0);
        repeat (58) pulse(1'b1, 1'b0);
        expectNow("set2359", 24'h235900, 1'b0);
        checkVal("setTicks", tickCnt - t0, 59);
        setMode = 1'b0;
        run(239, "235959",   24'h235959, 1'b0);
        run(1,   "rollover", 24'h000000, 1'b1);

        // Enter set mode mid-minute; prescaler frozen; minute wrap without hour carry.
        run(148, "sec37", 24'h000037, 1'b0);
        setMode = 1'b1;
        run(1,  "setClr", 24'h000000, 1'b0);
        run(50, "frozen", 24'h000000, 1'b0);
        repeat (5) pulse(1'b0, 1'b1);
        repeat (59) pulse(1'b1, 1'b0);
        expectNow("set0559", 24'h055900, 1'b0);
        incMin = 1'b1;
        run(1, "minWrap", 24'h050000, 1'b1);
        incMin = 1'b0;
        cycle(1);
        setMode = 1'b0;
        run(3, "restart3", 24'h050000, 1'b0);
        run(1, "restart4", 24'h050001, 1'b0);

        // Held buttons give one increment each; run-mode toggles are ignored.
        setMode = 1'b1;
        run(1, "setAgain", 24'h050000, 1'b0);
        t0 = tickCnt;
        incMin  = 1'b1;
        incHour = 1'b1;
        run(10, "bothHeld", 24'h060100, 1'b0);
        incMin  = 1'b0;
        incHour = 1'b0;
        cycle(1);
        checkVal("bothTick", tickCnt - t0, 1);
        setMode = 1'b0;
        repeat (3) begin
            incMin  = ~incMin;
            incHour = ~incHour;
            cycle(1);
        end
        incMin  = 1'b0;
        incHour = 1'b0;
        run(1, "runIgnore", 24'h060101, 1'b0);

        // Asynchronous reset from 12:34:56.
        doReset();
        setMode = 1'b1;
        cycle(1);
        repeat (12) pulse(1'b0, 1'b1);
        repeat (34) pulse(1'b1, 1'b0);
        setMode = 1'b0;
        run(224, "t123456", 24'h123456, 1'b0);
        #2 resetN = 1'b0;
        #1 expectNow("asyncRst", 24'h000000, 1'b0);
        cycle(3);
        expectNow("rstHold", 24'h000000, 1'b0);
        resetN = 1'b1;
        run(3, "post3", 24'h000000, 1'b0);
        run(1, "post4", 24'h000001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
